hcsr04_multi_capture: RTL and testbench
=======================================

HCSR04_MULTI_CAPTURE -- requirements
Module: hcsr04_multi_capture

Interface
REQ-001 The block SHALL have parameter T_CLK, default 10, input clock period in ns.
REQ-002 The block SHALL have parameter N_CH, default 4, number of sensor channels (1..16).
REQ-003 The block SHALL have parameter CNT_W, default 22, echo-time result width in bits.
REQ-004 The block SHALL have parameter TRIG_NS, default 10_000, trigger pulse width in ns.
REQ-005 The block SHALL have parameter WAIT_NS, default 1_000_000, maximum trigger-end to echo-rise wait in ns.
REQ-006 The block SHALL have parameter ECHO_NS, default 38_000_000, maximum echo-high time in ns.
REQ-007 The block SHALL have parameter HOLD_NS, default 60_000_000, holdoff between consecutive triggers in ns.
REQ-008 The block SHALL have port i_clk, input, 1 bit: the single clock.
REQ-009 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-010 The block SHALL have port i_enable, input, 1 bit: level enable for the measurement scan.
REQ-011 The block SHALL have port i_echo, input, N_CH bits: asynchronous sensor echo pins.
REQ-012 The block SHALL have port o_trigger, output, N_CH bits: sensor trigger pins.
REQ-013 The block SHALL have port o_echo_time, output, N_CH*CNT_W bits: per-channel last result in clock cycles, channel k at bits [k*CNT_W +: CNT_W].
REQ-014 The block SHALL have port o_timeout, output, N_CH bits: per-channel flag, set when the last measurement timed out.
REQ-015 The block SHALL have port o_valid, output, 1 bit: one-cycle strobe on each result update.
REQ-016 The block SHALL have port o_ch, output, clog2(N_CH) bits (min 1): channel index of the update signalled by o_valid.

Function
REQ-017 Derived counts SHALL be TRIG_C=TRIG_NS/T_CLK, WAIT_C=WAIT_NS/T_CLK, ECHO_C=ECHO_NS/T_CLK, HOLD_C=HOLD_NS/T_CLK; one shared counter sized to the largest count.
REQ-018 Each i_echo bit SHALL pass through a 2-FF synchronizer plus a third delay FF; rise = q1&!q2, fall = !q1&q2.
REQ-019 The FSM SHALL have states IDLE, TRIG, WAIT_ECHO, ECHO, HOLD.
REQ-020 IDLE: when i_enable=1, go to TRIG for the current channel pointer ch; otherwise stay.
REQ-021 TRIG: o_trigger[ch]=1 for exactly TRIG_C cycles, then 0, and go to WAIT_ECHO with counter=0; all other o_trigger bits stay 0 at all times.
REQ-022 WAIT_ECHO: on rise of channel ch go to ECHO with counter=0; if WAIT_C cycles elapse without rise, record result 0 with timeout=1; an echo already high at entry SHALL NOT count as a rise.
REQ-023 ECHO: counter increments every cycle; on fall of channel ch record result = counter value; if counter reaches ECHO_C with no fall, record result = ECHO_C with timeout=1.
REQ-024 A recorded result SHALL update o_echo_time[ch] and o_timeout[ch], pulse o_valid for one cycle and drive o_ch=ch, all in the cycle after the detecting cycle; then go to HOLD.
REQ-025 Results SHALL saturate at 2^CNT_W-1 if ECHO_C exceeds that range; the counter SHALL never wrap.
REQ-026 HOLD: wait HOLD_C cycles, advance ch round-robin (N_CH-1 wraps to 0), then go to TRIG if i_enable=1, else IDLE.
REQ-027 Deasserting i_enable mid-measurement SHALL NOT abort it; the measurement and holdoff complete first.
REQ-028 Echo activity on channels other than ch SHALL be ignored.
REQ-029 The result of a channel SHALL hold its value until that channel is next measured.

Reset
REQ-030 While i_rst=1 the block SHALL asynchronously force o_trigger=0, o_echo_time=0, o_timeout=0, o_valid=0, o_ch=0, ch=0, counter=0, synchronizers=0, state=IDLE.
REQ-031 Reset asserted mid-measurement SHALL drop o_trigger immediately and discard the in-flight measurement; after release the scan restarts at channel 0.

Verification (N_CH=2, CNT_W=16, T_CLK=10, TRIG_NS=100, WAIT_NS=1000, ECHO_NS=2000, HOLD_NS=500)
REQ-032 The bench SHALL cover: i_enable=1, ch0 echo high for 50 cycles after trigger -> o_trigger[0] high for exactly 10 cycles, o_valid with o_ch=0, o_echo_time[0] within 50±1, o_timeout[0]=0.
REQ-033 The bench SHALL cover: ch1 echo never rises -> 100 cycles after trigger end, o_valid with o_ch=1, o_echo_time[1]=0, o_timeout[1]=1.
REQ-034 The bench SHALL cover: ch0 echo stuck high -> o_echo_time[0]=200, o_timeout[0]=1; the next ch0 pass with a 30-cycle echo clears o_timeout[0].
REQ-035 The bench SHALL cover: ch1 pulsed while ch0 is measured -> ch0 result unaffected; o_trigger[1] never high during the ch0 measurement.
REQ-036 The bench SHALL cover: i_enable dropped during ECHO -> the current result is still reported, then IDLE with no further trigger.
REQ-037 The bench SHALL cover: i_rst pulsed during TRIG -> o_trigger=0 within the same cycle, all outputs 0, the next trigger goes to channel 0.

Source files
------------

// File: rtl/hcsr04_multi_capture.sv
// ============================================================================
// hcsr04_multi_capture
// ----------------------------------------------------------------------------
// Round-robin HC-SR04 ultrasonic ranging controller for N_CH sensors. One
// channel at a time is triggered and its echo pulse width is measured in clock
// cycles. A missing echo and an over-long echo are both reported as timeouts.
// One shared counter times every phase (trigger, echo wait, echo, holdoff).
//
// Ports
//   i_clk        single clock
//   i_rst        asynchronous active-high reset
//   i_enable     level enable for the measurement scan
//   i_echo       [N_CH]        asynchronous echo pins
//   o_trigger    [N_CH]        trigger pins (only the active channel ever pulses)
//   o_echo_time  [N_CH*CNT_W]  last result per channel, ch k at [k*CNT_W +: CNT_W]
//   o_timeout    [N_CH]        last measurement of the channel timed out
//   o_valid      one-cycle strobe on each result update
//   o_ch         channel index of the update signalled by o_valid
// ============================================================================
module hcsr04_multi_capture #(
    parameter int T_CLK   = 10,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 22,
    parameter int TRIG_NS = 10_000,
    parameter int WAIT_NS = 1_000_000,
    parameter int ECHO_NS = 38_000_000,
    parameter int HOLD_NS = 60_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [N_CH-1:0]          i_echo,
    output logic [N_CH-1:0]          o_trigger,
    output logic [N_CH*CNT_W-1:0]    o_echo_time,
    output logic [N_CH-1:0]          o_timeout,
    output logic                     o_valid,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] o_ch
);

    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TRIG_C = TRIG_NS / T_CLK;
    localparam int WAIT_C = WAIT_NS / T_CLK;
    localparam int ECHO_C = ECHO_NS / T_CLK;
    localparam int HOLD_C = HOLD_NS / T_CLK;
    localparam int MAX_TW = (TRIG_C > WAIT_C) ? TRIG_C : WAIT_C;
    localparam int MAX_EH = (ECHO_C > HOLD_C) ? ECHO_C : HOLD_C;
    localparam int MAX_C  = (MAX_TW > MAX_EH) ? MAX_TW : MAX_EH;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int XW     = (CW > CNT_W) ? CW : CNT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_ECHO,
        S_HOLD
    } state_t;

    state_t            r_state, w_state_d;
    logic [CW-1:0]     r_cnt, w_cnt_d;
    logic [CH_W-1:0]   r_ch, w_ch_d;
    logic [N_CH-1:0]   r_trig, w_trig_d;

    logic [N_CH-1:0]   r_sy1, r_sy2, r_sy3;
    logic              w_rise, w_fall;

    logic              w_rec;
    logic              w_rec_to;
    logic [CNT_W-1:0]  w_rec_val;

    logic [CNT_W-1:0]  r_time [N_CH];
    logic [N_CH-1:0]   r_to;
    logic              r_valid;
    logic [CH_W-1:0]   r_och;

    // Echo synchronizer: r_sy1/r_sy2 resynchronise, r_sy3 is the edge-detect delay.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sy1 <= '0;
            r_sy2 <= '0;
            r_sy3 <= '0;
        end else begin
            r_sy1 <= i_echo;
            r_sy2 <= r_sy1;
            r_sy3 <= r_sy2;
        end
    end

    // Only the active channel is observed; other channels' edges are ignored.
    assign w_rise = r_sy2[r_ch] & ~r_sy3[r_ch];
    assign w_fall = ~r_sy2[r_ch] & r_sy3[r_ch];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_trig  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_ch    <= w_ch_d;
            r_trig  <= w_trig_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_ch_d    = r_ch;
        w_trig_d  = '0;
        w_rec     = 1'b0;
        w_rec_to  = 1'b0;
        w_rec_val = '0;

        case (r_state)
            S_IDLE: begin
                w_cnt_d = '0;
                if (i_enable) w_state_d = S_TRIG;
            end
            S_TRIG: begin
                if (r_cnt == CW'(TRIG_C - 1)) begin
                    w_state_d = S_WAIT_ECHO;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            S_WAIT_ECHO: begin
                // A level already high at entry produces no edge, so it is not a rise.
                if (w_rise) begin
                    w_state_d = S_ECHO;
                    w_cnt_d   = '0;
                end else if (r_cnt == CW'(WAIT_C - 1)) begin
                    w_rec     = 1'b1;
                    w_rec_to  = 1'b1;
                    w_state_d = S_HOLD;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            S_ECHO: begin
                if (w_fall || r_cnt == CW'(ECHO_C)) begin
                    w_rec     = 1'b1;
                    w_rec_to  = ~w_fall;
                    // r_cnt stops at ECHO_C, so it never wraps; clamp to the result width.
                    if (XW'(r_cnt) > XW'({CNT_W{1'b1}})) w_rec_val = '1;
                    else                                  w_rec_val = CNT_W'(r_cnt);
                    w_state_d = S_HOLD;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == CW'(HOLD_C - 1)) begin
                    w_cnt_d   = '0;
                    w_ch_d    = (r_ch == CH_W'(N_CH - 1)) ? '0 : r_ch + 1'b1;
                    w_state_d = i_enable ? S_TRIG : S_IDLE;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
            end
        endcase

        // Trigger is registered from the next state so the pin is glitch-free.
        if (w_state_d == S_TRIG) w_trig_d[w_ch_d] = 1'b1;
    end

    // Result registers: written in the detecting cycle, visible the cycle after.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < N_CH; k++) r_time[k] <= '0;
            r_to    <= '0;
            r_valid <= 1'b0;
            r_och   <= '0;
        end else begin
            r_valid <= w_rec;
            if (w_rec) begin
                r_time[r_ch] <= w_rec_val;
                r_to[r_ch]   <= w_rec_to;
                r_och        <= r_ch;
            end
        end
    end

    always_comb begin
        o_echo_time = '0;
        for (int unsigned k = 0; k < N_CH; k++) o_echo_time[k*CNT_W +: CNT_W] = r_time[k];
    end

    assign o_trigger = r_trig;
    assign o_timeout = r_to;
    assign o_valid   = r_valid;
    assign o_ch      = r_och;

endmodule

// File: tb/tb_hcsr04_multi_capture.sv
// ============================================================================
// tb_hcsr04_multi_capture
// Directed + randomized bench for hcsr04_multi_capture with N_CH=2, CNT_W=16,
// 10 ns clock: TRIG 10, WAIT 100, ECHO 200, HOLD 50 cycles. A reference model
// keeps the expected per-channel result/timeout and the scan channel pointer.
// ============================================================================
module tb_hcsr04_multi_capture;

    localparam int TRIG_CYC = 10;
    localparam int WAIT_CYC = 100;
    localparam int ECHO_CYC = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  echo;
    logic [1:0]  o_trigger;
    logic [31:0] o_echo_time;
    logic [1:0]  o_timeout;
    logic        o_valid;
    logic [0:0]  o_ch;

    always #5 clk = ~clk;

    hcsr04_multi_capture #(
        .T_CLK  (10),
        .N_CH   (2),
        .CNT_W  (16),
        .TRIG_NS(100),
        .WAIT_NS(1000),
        .ECHO_NS(2000),
        .HOLD_NS(500)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (en),
        .i_echo     (echo),
        .o_trigger  (o_trigger),
        .o_echo_time(o_echo_time),
        .o_timeout  (o_timeout),
        .o_valid    (o_valid),
        .o_ch       (o_ch)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int exp_time [2];
    bit exp_to   [2];
    int exp_ch;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // kind 0: echo pulse of n cycles; 1: no echo; 2: echo rises and stays high.
    // A pulse n cycles wide is timed from rise detection (count 0) to fall
    // detection; both edges see the same synchronizer delay, so the result is n-1.
    task automatic run_meas(input int kind, input int n, input bit other, input bit drop_en);
        int ch;
        int oth;
        int w;
        int t;
        bit bad;
        logic [1:0] oh;
        ch  = exp_ch;
        oth = 1 - ch;
        oh  = 2'b01 << ch;
        bad = 1'b0;

        t = 0;
        while (o_trigger == 2'b00 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("trig_onehot", o_trigger, oh);

        w = 0;
        while (o_trigger != 2'b00 && w < 100) begin
            if (o_trigger !== oh) bad = 1'b1;
            w++;
            @(negedge clk);
        end
        check("trig_width", w, TRIG_CYC);

        if (kind != 1) begin
            repeat (3) @(negedge clk);
            if (other) begin
                echo[oth] = 1'b1;
                @(negedge clk);
            end
            echo[ch] = 1'b1;
            if (kind == 0) begin
                for (int i = 0; i < n; i++) begin
                    if (drop_en && i == 5) en = 1'b0;
                    if (other && i == n / 2) echo[oth] = 1'b0;
                    @(negedge clk);
                end
                echo[ch] = 1'b0;
            end
        end

        t = 0;
        while (!o_valid && t < 500) begin
            if (o_trigger != 2'b00) bad = 1'b1;
            @(negedge clk);
            t++;
        end
        check("valid_seen", o_valid, 1);
        if (kind == 1) check("wait_to_latency", t, WAIT_CYC);

        case (kind)
            0:       begin exp_time[ch] = n - 1;    exp_to[ch] = 1'b0; end
            1:       begin exp_time[ch] = 0;        exp_to[ch] = 1'b1; end
            default: begin exp_time[ch] = ECHO_CYC; exp_to[ch] = 1'b1; end
        endcase

        check("o_ch", o_ch, ch);
        check("echo_time_act", o_echo_time[ch*16 +: 16], exp_time[ch]);
        check("timeout_act", o_timeout[ch], exp_to[ch]);
        check("echo_time_held", o_echo_time[oth*16 +: 16], exp_time[oth]);
        check("timeout_held", o_timeout[oth], exp_to[oth]);
        check("trig_quiet", bad, 0);

        @(negedge clk);
        check("valid_one_cycle", o_valid, 0);
        if (kind == 2) echo[ch] = 1'b0;
        exp_ch = oth;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        bit bad;
        rst  = 1'b1;
        en   = 1'b0;
        echo = 2'b00;
        exp_time[0] = 0; exp_time[1] = 0;
        exp_to[0]   = 0; exp_to[1]   = 0;
        exp_ch      = 0;

        repeat (3) @(negedge clk);
        check("rst_trigger", o_trigger, 0);
        check("rst_echo_time", o_echo_time, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_valid", o_valid, 0);
        check("rst_ch", o_ch, 0);
        rst = 1'b0;

        // Disabled: the scan must not start.
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_trigger != 2'b00 || o_valid) bad = 1'b1;
        end
        check("idle_disabled", bad, 0);

        en = 1'b1;
        run_meas(0, 50, 0, 0);          // ch0 normal 50-cycle echo
        run_meas(1, 0, 0, 0);           // ch1 no echo -> wait timeout
        run_meas(2, 0, 0, 0);           // ch0 stuck high -> echo timeout
        run_meas(0, $urandom_range(2, 190), 0, 0);
        run_meas(0, 30, 0, 0);          // ch0 30-cycle echo clears the timeout
        run_meas(0, $urandom_range(2, 190), 0, 0);
        run_meas(0, $urandom_range(20, 120), 1, 0);  // ch0 with ch1 pulsing

        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) == 0) run_meas(1, 0, 0, 0);
            else                           run_meas(0, $urandom_range(2, 190), 0, 0);
        end

        // Enable dropped during ECHO: result still reported, then no more triggers.
        run_meas(0, 40, 0, 1);
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (o_trigger != 2'b00 || o_valid) bad = 1'b1;
        end
        check("idle_after_drop", bad, 0);

        en = 1'b1;
        if (exp_ch == 0) run_meas(0, $urandom_range(2, 190), 0, 0);

        // Reset during the ch1 trigger pulse.
        t = 0;
        while (o_trigger == 2'b00 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("pre_rst_trig", o_trigger, 2'b10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_trigger", o_trigger, 0);
        check("async_rst_echo_time", o_echo_time, 0);
        check("async_rst_timeout", o_timeout, 0);
        check("async_rst_valid", o_valid, 0);
        check("async_rst_ch", o_ch, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_time[0] = 0; exp_time[1] = 0;
        exp_to[0]   = 0; exp_to[1]   = 0;
        exp_ch      = 0;
        run_meas(0, 25, 0, 0);          // scan restarts on ch0

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
